morse_code_decoder: RTL and testbench

Receive-side counterpart of the board's Morse generator. Samples a single key input (push-button or looped-back LED line), measures mark and space durations in unit ticks, classifies each mark as dot or dash, and detects the end of a letter from a long space. It decodes letters A–H into the same 3-bit letter code the generator takes on its switches, and reports each result with a one-cycle Valid or Error pulse.

---
 rtl/morse_code_decoder.sv | 167 ++++++++++++++++
 tb/tb_morse_code_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/morse_code_decoder.sv
// Morse receiver: times key marks and spaces in unit ticks and decodes letters A-H
// into the generator's 3-bit letter code, pulsing Valid or Error once per letter.
module morse_code_decoder #(
    parameter int UNIT       = 25_000_000,
    parameter int UNIT_N     = 25,
    parameter int DASH_UNITS = 2,
    parameter int GAP_UNITS  = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Key,
    output logic [2:0] Letter,
    output logic       Valid,
    output logic       Error,
    output logic [3:0] Symbol,
    output logic [2:0] Size,
    output logic       Busy
);

    localparam int GAP_W = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    state_t              state_q, state_d;
    logic                key_m, key_s;
    logic [UNIT_N-1:0]   presc_q;
    logic                tick;
    logic [2:0]          mark_q, mark_d, mark_inc, mark_now;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [3:0]          pattern_q, pattern_d;
    logic [2:0]          count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                is_dash;
    logic                emit;
    logic                hit;
    logic [2:0]          dec_letter;

    // Two-flop synchronizer for the asynchronous key line.
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample the pre-edge values; blocking here would collapse the two stages.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            key_m <= 1'b0;
            key_s <= 1'b0;
        end else begin
            key_m <= Key;
            key_s <= key_m;
        end
    end

    assign tick     = (presc_q == UNIT_N'(UNIT - 1));
    assign mark_inc = (mark_q == 3'd7) ? mark_q : mark_q + 3'd1;
    // A tick landing on the release cycle still counts toward this mark.
    assign mark_now = tick ? mark_inc : mark_q;
    assign is_dash  = (int'(mark_now) >= DASH_UNITS);

    always_comb begin
        // NOTE: defaults first so every path assigns every variable; a missing
        // branch would otherwise infer a latch.
        state_d    = state_q;
        mark_d     = mark_q;
        gap_d      = gap_q;
        pattern_d  = pattern_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        emit       = 1'b0;
        unique case (state_q)
            IDLE: begin
                pattern_d  = '0;
                count_d    = '0;
                overflow_d = 1'b0;
                if (key_s) begin
                    state_d = MARK;
                    mark_d  = '0;
                end
            end
            MARK: begin
                mark_d = mark_now;
                if (!key_s) begin
                    if (count_q < 3'd4) begin
                        pattern_d = pattern_q | ({is_dash, 3'b000} >> count_q);
                        count_d   = count_q + 3'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    state_d = SPACE;
                    gap_d   = '0;
                end
            end
            SPACE: begin
                if (tick) gap_d = gap_q + GAP_W'(1);
                // The terminating tick takes priority over a new mark.
                if (tick && gap_q == GAP_W'(GAP_UNITS - 1)) begin
                    state_d = IDLE;
                    emit    = 1'b1;
                end else if (key_s) begin
                    state_d = MARK;
                    mark_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit        = 1'b1;
        dec_letter = 3'd0;
        case ({pattern_q, count_q})
            {4'b0100, 3'd2}: dec_letter = 3'd0;
            {4'b1000, 3'd4}: dec_letter = 3'd1;
            {4'b1010, 3'd4}: dec_letter = 3'd2;
            {4'b1000, 3'd3}: dec_letter = 3'd3;
            {4'b0000, 3'd1}: dec_letter = 3'd4;
            {4'b0010, 3'd4}: dec_letter = 3'd5;
            {4'b1100, 3'd3}: dec_letter = 3'd6;
            {4'b0000, 3'd4}: dec_letter = 3'd7;
            default:         hit        = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            mark_q     <= '0;
            gap_q      <= '0;
            pattern_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Restarting on each transition keeps unit counts exact per mark/space.
            presc_q    <= (state_d != state_q || tick) ? '0 : presc_q + UNIT_N'(1);
            mark_q     <= mark_d;
            gap_q      <= gap_d;
            pattern_q  <= pattern_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Letter <= '0;
            Valid  <= 1'b0;
            Error  <= 1'b0;
            Symbol <= '0;
            Size   <= '0;
        end else begin
            Valid <= 1'b0;
            Error <= 1'b0;
            if (emit) begin
                Symbol <= pattern_q;
                Size   <= count_q;
                if (hit && !overflow_q) begin
                    Valid  <= 1'b1;
                    Letter <= dec_letter;
                end else begin
                    Error <= 1'b1;
                end
            end
        end
    end

    assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_morse_code_decoder.sv
// Randomized bench for morse_code_decoder: keys letters as mark/space lengths and
// checks every Valid/Error pulse against a dot/dash string model of the alphabet.
module tb_morse_code_decoder;

    localparam int UNIT       = 4;
    localparam int DASH_UNITS = 2;
    localparam int GAP_UNITS  = 3;
    localparam int DOT        = UNIT;
    localparam int DASH       = 3 * UNIT;
    localparam int SGAP       = UNIT;
    localparam int LGAP       = 4 * UNIT;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Key = 1'b0;
    logic [2:0] Letter;
    logic       Valid;
    logic       Error;
    logic [3:0] Symbol;
    logic [2:0] Size;
    logic       Busy;

    morse_code_decoder #(
        .UNIT       (UNIT),
        .UNIT_N     (3),
        .DASH_UNITS (DASH_UNITS),
        .GAP_UNITS  (GAP_UNITS)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Key    (Key),
        .Letter (Letter),
        .Valid  (Valid),
        .Error  (Error),
        .Symbol (Symbol),
        .Size   (Size),
        .Busy   (Busy)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    string      morse [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
    int         mark_len [8];
    int         gap_len [8];
    int         n_marks;
    logic [2:0] last_letter = 3'd0;
    logic [12:0] exp_q [$];
    int         n_events = 0;

    // Reference: mark length -> whole units (capped at 7) -> dot/dash string -> table lookup.
    task automatic expect_letter();
        string      s = "";
        logic [3:0] sym = 4'b0000;
        logic [2:0] size;
        int         units;
        int         found = -1;
        logic       dash;
        for (int i = 0; i < n_marks; i++) begin
            units = mark_len[i] / UNIT;
            if (units > 7) units = 7;
            dash = (units >= DASH_UNITS);
            if (dash) s = {s, "-"};
            else      s = {s, "."};
            if (i < 4) sym[3-i] = dash;
        end
        size = (n_marks > 4) ? 3'd4 : 3'(n_marks);
        for (int k = 0; k < 8; k++)
            if (s == morse[k]) found = k;
        if (found >= 0) begin
            last_letter = 3'(found);
            exp_q.push_back({1'b1, 1'b0, 3'(found), sym, size, 1'b0});
        end else begin
            exp_q.push_back({1'b0, 1'b1, last_letter, sym, size, 1'b0});
        end
    endtask

    task automatic send_letter(input int end_gap);
        expect_letter();
        for (int i = 0; i < n_marks; i++) begin
            Key = 1'b1;
            repeat (mark_len[i]) @(negedge Clk);
            Key = 1'b0;
            if (i < n_marks - 1) repeat (gap_len[i]) @(negedge Clk);
        end
        repeat (end_gap) @(negedge Clk);
    endtask

    task automatic set_pattern(input string p);
        n_marks = p.len();
        for (int i = 0; i < n_marks; i++) begin
            mark_len[i] = (p[i] == "-") ? DASH : DOT;
            gap_len[i]  = SGAP;
        end
    endtask

    // Random timing kept clear of the dot/dash threshold even if one cycle is lost.
    task automatic set_random(input string p);
        n_marks = p.len();
        for (int i = 0; i < n_marks; i++) begin
            mark_len[i] = (p[i] == "-") ? int'($urandom_range(9, 40)) : int'($urandom_range(2, 7));
            gap_len[i]  = int'($urandom_range(1, GAP_UNITS * UNIT - 1));
        end
    endtask

    always @(negedge Clk) begin
        logic [12:0] obs;
        if (Reset && (Valid || Error)) begin
            obs = {Valid, Error, Letter, Symbol, Size, Busy};
            n_events++;
            if (exp_q.size() == 0) check("spurious_pulse", 32'(obs), 32'(0));
            else check($sformatf("letter%0d", n_events), 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        string p;
        repeat (3) @(negedge Clk);
        check("reset_outputs", 32'({Letter, Valid, Error, Symbol, Size, Busy}), 32'(0));
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("idle_busy", 32'(Busy), 32'(0));

        set_pattern(".-");
        send_letter(LGAP);
        repeat (4) @(negedge Clk);
        check("busy_after_A", 32'(Busy), 32'(0));

        for (int k = 0; k < 8; k++) begin
            set_pattern(morse[k]);
            send_letter(LGAP);
        end
        set_pattern("---");   send_letter(LGAP);
        set_pattern("....."); send_letter(LGAP);

        n_marks = 1; mark_len[0] = 40;
        send_letter(LGAP);

        // Release exactly on a tick: 7 cycles is a dot, 8 cycles a dash.
        n_marks = 2; mark_len[0] = 7; mark_len[1] = 8; gap_len[0] = SGAP;
        send_letter(LGAP);
        n_marks = 1; mark_len[0] = 8;
        send_letter(LGAP);

        // Next mark begins on the terminating tick of the previous letter.
        set_pattern(".");    send_letter(GAP_UNITS * UNIT);
        set_pattern("-..."); send_letter(LGAP);
        repeat (20) @(negedge Clk);

        Key = 1'b1; repeat (DASH) @(negedge Clk);
        Key = 1'b0; repeat (SGAP) @(negedge Clk);
        Key = 1'b1; repeat (6) @(negedge Clk);
        check("busy_mid_letter", 32'(Busy), 32'(1));
        Reset = 1'b0;
        Key   = 1'b0;
        @(negedge Clk);
        check("outputs_in_reset", 32'({Letter, Valid, Error, Symbol, Size, Busy}), 32'(0));
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        last_letter = 3'd0;
        repeat (2) @(negedge Clk);
        set_pattern(".");
        send_letter(LGAP);

        repeat (40) begin
            if ($urandom_range(0, 1) == 1) begin
                p = morse[$urandom_range(0, 7)];
            end else begin
                p = "";
                repeat ($urandom_range(1, 5)) begin
                    if ($urandom_range(0, 1) == 1) p = {p, "-"};
                    else                           p = {p, "."};
                end
            end
            set_random(p);
            send_letter(int'($urandom_range(GAP_UNITS * UNIT, GAP_UNITS * UNIT + 8)));
        end

        repeat (40) @(negedge Clk);
        check("pending_letters", 32'(exp_q.size()), 32'(0));
        check("idle_at_end", 32'(Busy), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
